// File: rtl/muldiv_unit_pkg.sv
// Shared decode constants, ALU op classes and FSM state encoding for the
// multi-cycle multiply/divide unit.
package muldiv_unit_pkg;

    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_RTYPE = 3'b010,
        ALU_ANDI  = 3'b011,
        ALU_ORI   = 3'b100,
        ALU_XORI  = 3'b101,
        ALU_SLTI  = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_e;

    // 0x18..0x1B: MULT, MULTU, DIV, DIVU
    function automatic logic is_muldiv(input logic [5:0] f);
        return f[5:2] == 4'b0110;
    endfunction

    // 0x10..0x13: MFHI, MTHI, MFLO, MTLO
    function automatic logic is_hilo_move(input logic [5:0] f);
        return f[5:2] == 4'b0100;
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative shift-add multiply / restoring divide on one 2*WIDTH accumulator,
// with combinational sign fix-up of the final result.
module muldiv_datapath
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_div_zero
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_orig_a;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_zero;

    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH-1:0]   w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_sign_a = i_signed & i_op_a[WIDTH-1];
    assign w_sign_b = i_signed & i_op_b[WIDTH-1];
    assign w_abs_a  = w_sign_a ? -i_op_a : i_op_a;
    assign w_abs_b  = w_sign_b ? -i_op_b : i_op_b;

    // Multiply: low half holds the multiplier, consumed LSB-first while the
    // partial product grows into the high half.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: high half is the remainder, low half shifts dividend out / quotient in.
    assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_ge    = w_div_shift >= {1'b0, r_opnd};
    assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
    assign w_div_next  = {(w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_opnd   <= '0;
            r_orig_a <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_zero   <= 1'b0;
        end else if (i_load) begin
            r_acc    <= {{WIDTH{1'b0}}, w_abs_a};
            r_opnd   <= w_abs_b;
            r_orig_a <= i_op_a;
            r_is_div <= i_is_div;
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            r_zero   <= (i_op_b == '0);
        end else if (i_step) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
        end
    end

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        o_hi = w_prod[2*WIDTH-1:WIDTH];
        o_lo = w_prod[WIDTH-1:0];
        if (r_is_div) begin
            o_hi = r_zero ? r_orig_a : w_rem;
            o_lo = r_zero ? '1 : w_quo;
        end
    end

    assign o_div_zero = r_is_div & r_zero;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit beside the EX-stage ALU: decode, sequencing FSM,
// pipeline stall and architectural HI/LO registers.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [2:0]       aluOP,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             mfValid,
    output logic [WIDTH-1:0] mfData,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_dec;
    logic               w_muldiv;
    logic               w_busy;
    logic               w_accept;
    logic               w_step;
    logic               w_mf;
    logic [WIDTH-1:0]   w_dp_hi;
    logic [WIDTH-1:0]   w_dp_lo;
    logic               w_dp_dz;

    assign w_dec    = valid && (aluOP == ALU_RTYPE);
    assign w_muldiv = w_dec && is_muldiv(funct);
    assign w_busy   = (r_state != IDLE);
    assign w_accept = w_muldiv && !w_busy;
    assign w_step   = (r_state == MUL) || (r_state == DIV);
    assign w_mf     = w_dec && ((funct == FUNCT_MFHI) || (funct == FUNCT_MFLO));

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_is_div   (funct[1]),
        .i_signed   (!funct[0]),
        .i_op_a     (opA),
        .i_op_b     (opB),
        .o_hi       (w_dp_hi),
        .o_lo       (w_dp_lo),
        .o_div_zero (w_dp_dz)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = funct[1] ? DIV : MUL;
            MUL,
            DIV:     if (r_cnt == '0) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= (r_state == FIX);
            if (w_accept) begin
                r_cnt <= CNT_W'(WIDTH - 1);
                r_dbz <= 1'b0;
            end else if (w_step && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // MTHI/MTLO can only land in IDLE, so they never collide with FIX.
            if (r_state == FIX) begin
                r_hi  <= w_dp_hi;
                r_lo  <= w_dp_lo;
                r_dbz <= w_dp_dz;
            end else if (!w_busy && w_dec && (funct == FUNCT_MTHI)) begin
                r_hi <= opA;
            end else if (!w_busy && w_dec && (funct == FUNCT_MTLO)) begin
                r_lo <= opA;
            end
        end
    end

    assign busy      = w_busy;
    assign stall     = w_busy && (w_muldiv || (w_dec && is_hilo_move(funct)));
    assign done      = r_done;
    assign mfValid   = w_mf && !w_busy;
    assign mfData    = (w_mf && !w_busy) ? ((funct == FUNCT_MFHI) ? r_hi : r_lo) : '0;
    assign divByZero = r_dbz;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: reset, HI/LO moves, signed/unsigned
// multiply and divide, divide-by-zero, stall handling and mid-op reset.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid = 1'b0;
    logic [2:0]   aluOP = 3'b000;
    logic [5:0]   funct = 6'h00;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic         stall, busy, done, mfValid, divByZero;
    logic [W-1:0] mfData, hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .aluOP     (aluOP),
        .funct     (funct),
        .opA       (opA),
        .opB       (opB),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .mfValid   (mfValid),
        .mfData    (mfData),
        .divByZero (divByZero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        valid = 1'b1;
        aluOP = 3'b010;
        funct = f;
        opA   = a;
        opB   = b;
    endtask

    task automatic idle_inputs();
        valid = 1'b0;
        aluOP = 3'b000;
        funct = 6'h00;
        opA   = '0;
        opB   = '0;
    endtask

    // Called on the first negedge after accept; returns on the done negedge.
    task automatic wait_done(output int busy_n, output int done_at);
        busy_n  = 0;
        done_at = -1;
        for (int k = 1; k <= 100; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_at = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, stall, done, mfValid, divByZero} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000", {busy, stall, done, mfValid, divByZero});
        end
        checks++;
        if ({hi, lo, mfData} !== '0) begin
            errors++;
            $display("FAIL reset_data got hi=%h lo=%h mf=%h exp 0", hi, lo, mfData);
        end
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset done");
    endtask

    task automatic test_moves();
        drive(6'h11, 32'h12345678, '0);
        @(negedge clk);
        drive(6'h13, 32'hCAFEBABE, '0);
        @(negedge clk);
        drive(6'h10, '0, '0);
        #1;
        checks++;
        if (mfValid !== 1'b1 || mfData !== 32'h12345678 || stall !== 1'b0) begin
            errors++;
            $display("FAIL mfhi got v=%b d=%h s=%b exp v=1 d=12345678 s=0", mfValid, mfData, stall);
        end
        drive(6'h12, '0, '0);
        #1;
        checks++;
        if (mfValid !== 1'b1 || mfData !== 32'hCAFEBABE) begin
            errors++;
            $display("FAIL mflo got v=%b d=%h exp v=1 d=cafebabe", mfValid, mfData);
        end
        aluOP = 3'b000;
        #1;
        checks++;
        if (mfValid !== 1'b0 || mfData !== '0) begin
            errors++;
            $display("FAIL non_rtype got v=%b d=%h exp v=0 d=0", mfValid, mfData);
        end
        @(negedge clk);
        idle_inputs();
        $display("moves hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_mult_signed();
        int b_n, d_at;
        drive(6'h18, 32'hFFFFFFFD, 32'd7);
        @(negedge clk);
        idle_inputs();
        wait_done(b_n, d_at);
        checks++;
        if (b_n !== 33 || d_at !== 34) begin
            errors++;
            $display("FAIL mult_latency got busy=%0d done_at=%0d exp busy=33 done_at=34", b_n, d_at);
        end
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
            errors++;
            $display("FAIL mult_result got hi=%h lo=%h exp hi=ffffffff lo=ffffffeb", hi, lo);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got done=%b busy=%b exp 0 0", done, busy);
        end
        $display("MULT -3*7 hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_back_to_back();
        int b_n, d_at, s_n;
        drive(6'h19, 32'd3, 32'd4);
        @(negedge clk);
        drive(6'h1B, 32'd100, 32'd7);
        s_n = 0;
        for (int k = 1; k <= 100; k++) begin
            if (!stall) break;
            s_n++;
            @(negedge clk);
        end
        checks++;
        if (s_n !== 33 || done !== 1'b1 || hi !== 32'd0 || lo !== 32'd12) begin
            errors++;
            $display("FAIL b2b_first got stalls=%0d done=%b hi=%h lo=%h exp 33 1 0 c", s_n, done, hi, lo);
        end
        @(negedge clk);
        idle_inputs();
        wait_done(b_n, d_at);
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2 || divByZero !== 1'b0 || d_at !== 34) begin
            errors++;
            $display("FAIL divu got lo=%h hi=%h dbz=%b done_at=%0d exp e 2 0 34", lo, hi, divByZero, d_at);
        end
        $display("DIVU 100/7 lo=%h hi=%h", lo, hi);
    endtask

    task automatic test_div_signed();
        int b_n, d_at;
        @(negedge clk);
        drive(6'h1A, 32'hFFFFFFF9, 32'd2);
        @(negedge clk);
        idle_inputs();
        wait_done(b_n, d_at);
        checks++;
        if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL div_signed got lo=%h hi=%h exp fffffffd ffffffff", lo, hi);
        end
        $display("DIV -7/2 lo=%h hi=%h", lo, hi);
    endtask

    task automatic test_div_zero();
        int b_n, d_at;
        @(negedge clk);
        drive(6'h1A, 32'd5, 32'd0);
        @(negedge clk);
        idle_inputs();
        wait_done(b_n, d_at);
        checks++;
        if (lo !== 32'hFFFFFFFF || hi !== 32'd5 || divByZero !== 1'b1 || b_n !== 33) begin
            errors++;
            $display("FAIL div_zero got lo=%h hi=%h dbz=%b busy=%0d exp ffffffff 5 1 33", lo, hi, divByZero, b_n);
        end
        $display("DIV 5/0 lo=%h hi=%h dbz=%b", lo, hi, divByZero);
    endtask

    task automatic test_mflo_stall();
        int s_n, viol;
        logic got;
        @(negedge clk);
        drive(6'h19, 32'h00010000, 32'h00010000);
        @(negedge clk);
        drive(6'h12, '0, '0);
        #1;
        checks++;
        if (divByZero !== 1'b0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL dbz_clear got dbz=%b stall=%b exp 0 1", divByZero, stall);
        end
        s_n = 0;
        viol = 0;
        got = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (!busy) begin
                got = 1'b1;
                break;
            end
            if (stall) s_n++;
            if (!stall || mfValid) viol++;
            @(negedge clk);
        end
        checks++;
        if (!got || s_n !== 33 || viol !== 0) begin
            errors++;
            $display("FAIL mflo_stall got ended=%b stalls=%0d bad=%0d exp 1 33 0", got, s_n, viol);
        end
        checks++;
        if (mfValid !== 1'b1 || mfData !== 32'd0 || done !== 1'b1 || stall !== 1'b0 || hi !== 32'd1) begin
            errors++;
            $display("FAIL mflo_done got v=%b d=%h done=%b stall=%b hi=%h exp 1 0 1 0 1",
                     mfValid, mfData, done, stall, hi);
        end
        @(negedge clk);
        idle_inputs();
        $display("MULTU 0x10000^2 + MFLO hi=%h lo=%h", hi, lo);
    endtask

    task automatic test_reset_mid();
        int b_n, d_at;
        drive(6'h18, 32'd6, 32'hFFFFFFFB);
        @(negedge clk);
        idle_inputs();
        repeat (9) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got %b exp 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, stall, done, mfValid, divByZero} !== 5'b0 || hi !== '0 || lo !== '0 || mfData !== '0) begin
            errors++;
            $display("FAIL mid_reset got flags=%b hi=%h lo=%h exp 0", {busy, stall, done, mfValid, divByZero}, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(6'h18, 32'd6, 32'hFFFFFFFB);
        @(negedge clk);
        idle_inputs();
        wait_done(b_n, d_at);
        checks++;
        if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFE2 || d_at !== 34) begin
            errors++;
            $display("FAIL post_reset_mult got hi=%h lo=%h done_at=%0d exp ffffffff ffffffe2 34", hi, lo, d_at);
        end
        $display("MULT 6*-5 after reset hi=%h lo=%h", hi, lo);
    endtask

    initial begin
        test_reset();
        test_moves();
        test_mult_signed();
        test_back_to_back();
        test_div_signed();
        test_div_zero();
        test_mflo_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
